// File: rtl/rr_arb_mux.sv
// Arbitrating mux: picks one valid input channel per cycle into a single output register.
// Define RR_ARB_MUX_RR_EN for round-robin arbitration; the default build is fixed priority (lowest index wins).
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    localparam int SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NCH-1:0]         in_valid,
    input  logic [NCH*WIDTH-1:0]   in_data,
    output logic [NCH-1:0]         in_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        out_sel,
    input  logic                   out_ready
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_sel_q,   out_sel_d;
    logic [SELW-1:0]  ptr;

    logic             load;
    logic             in_xfer;
    logic             lo_valid, hi_valid, grant_valid;
    logic [SELW-1:0]  lo_idx, hi_idx, grant_idx;
    logic [WIDTH-1:0] sel_data;

`ifdef RR_ARB_MUX_RR_EN
    logic [SELW-1:0]  ptr_q, ptr_d;
    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    assign load = !out_valid_q || out_ready;

    // Two scans: lowest valid channel at or above ptr, and lowest valid overall (the wrap-around case).
    always_comb begin
        lo_valid = 1'b0;
        lo_idx   = '0;
        hi_valid = 1'b0;
        hi_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                lo_valid = 1'b1;
                lo_idx   = SELW'(i);
                if (i >= int'(ptr)) begin
                    hi_valid = 1'b1;
                    hi_idx   = SELW'(i);
                end
            end
        end
        grant_valid = lo_valid;
        grant_idx   = hi_valid ? hi_idx : lo_idx;
    end

    // Gated by resetn so no source sees an accept while the block is held in reset.
    assign in_xfer = resetn && load && grant_valid;

    always_comb begin
        in_ready = '0;
        if (in_xfer) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant_idx == SELW'(i)) begin
                sel_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = sel_data;
            out_sel_d   = grant_idx;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef RR_ARB_MUX_RR_EN
    always_comb begin
        ptr_d = ptr_q;
        if (in_xfer) begin
            ptr_d = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
`ifdef RR_ARB_MUX_RR_EN
            ptr_q       <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
`ifdef RR_ARB_MUX_RR_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Bench for rr_arb_mux: scoreboard of granted words, arbiter reference model, directed and random phases.
// Expectations follow RR_ARB_MUX_RR_EN the same way the design does.
module tb_rr_arb_mux;

    localparam int WIDTH = 32;
    localparam int NCH   = 4;
    localparam int SELW  = 2;
    localparam int W     = SELW + WIDTH;

    logic                 clk;
    logic                 resetn;
    logic [NCH-1:0]       in_valid;
    logic [NCH*WIDTH-1:0] in_data;
    logic [NCH-1:0]       in_ready;
    logic                 out_valid;
    logic [WIDTH-1:0]     out_data;
    logic [SELW-1:0]      out_sel;
    logic                 out_ready;

    logic [W-1:0] exp_q[$];
    logic         m_valid;
    int           m_ptr;
    int           n_checks;
    int           n_errors;

    rr_arb_mux #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_grant(input logic [NCH-1:0] v, input int p);
        for (int k = 0; k < NCH; k++) begin
            if (v[(p + k) % NCH]) return (p + k) % NCH;
        end
        return -1;
    endfunction

    // driver tasks
    task automatic set_ch(input int ch, input logic [WIDTH-1:0] d);
        in_data[ch*WIDTH +: WIDTH] = d;
    endtask

    task automatic rand_data();
        for (int c = 0; c < NCH; c++) set_ch(c, $urandom);
    endtask

    // Checks the upcoming edge against the model at the falling edge, then advances one cycle.
    task automatic step();
        logic [NCH-1:0] m_ready;
        logic [W-1:0]   e;
        logic           ld;
        int             g;
        @(negedge clk);
        ld = !m_valid || out_ready;
        g  = model_grant(in_valid, m_ptr);
        m_ready = '0;
        if (ld && g >= 0) m_ready[g] = 1'b1;
        check("in_ready", in_ready, m_ready);
        check("out_valid", out_valid, m_valid);
        if (m_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("out_data", out_data, e[WIDTH-1:0]);
                check("out_sel", out_sel, e[WIDTH +: SELW]);
            end
            m_valid = 1'b0;
        end
        if (ld && g >= 0) begin
            exp_q.push_back({g[SELW-1:0], in_data[g*WIDTH +: WIDTH]});
            m_valid = 1'b1;
`ifdef RR_ARB_MUX_RR_EN
            m_ptr = (g + 1) % NCH;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_sel"}, out_sel, 0);
        check({tag, "_ready"}, in_ready, 0);
    endtask

    initial begin
        int rr_seq[5];
        rr_seq = '{0, 1, 2, 3, 0};
        n_checks  = 0;
        n_errors  = 0;
        m_valid   = 1'b0;
        m_ptr     = 0;
        resetn    = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;

        // reset held under arbitrary inputs
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            in_valid  = NCH'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 1));
            rand_data();
            @(negedge clk);
            check_reset_outputs("reset");
        end
        @(posedge clk);
        #1;
        resetn    = 1'b1;
        out_ready = 1'b1;

        // all channels requesting: fairness sequence (or ch0 every time under fixed priority)
        in_valid = '1;
        for (int k = 0; k < 5; k++) begin
            rand_data();
            step();
            if (k == 0) check("first_grant", out_sel, 0);
`ifdef RR_ARB_MUX_RR_EN
            check("rr_seq", out_sel, rr_seq[k]);
`else
            check("fp_seq", out_sel, 0);
`endif
            check("seq_valid", out_valid, 1);
        end
        in_valid = '0;
        step();
        step();

        // backpressure on a word from ch2
        in_valid = 4'b0100;
        set_ch(2, 32'hDEAD_BEEF);
        step();
        out_ready = 1'b0;
        in_valid  = '1;
        for (int k = 0; k < 5; k++) begin
            rand_data();
            step();
            check("hold_data", out_data, 32'hDEAD_BEEF);
            check("hold_sel", out_sel, 2);
            check("hold_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        in_valid  = '0;
        step();
        check("bp_drained", out_valid, 0);

        // skip and wrap: after ch2 the pointer sits at 3
        in_valid = 4'b0101;
        rand_data();
        step();
        check("wrap_grant0", out_sel, 0);
        step();
`ifdef RR_ARB_MUX_RR_EN
        check("wrap_grant2", out_sel, 2);
`else
        check("wrap_grant_fp", out_sel, 0);
`endif
        in_valid = '0;
        step();

        // simultaneous drain and fill
        in_valid = 4'b0001;
        rand_data();
        step();
        in_valid = 4'b0010;
        set_ch(1, 32'h0000_0011);
        step();
        check("fill_data", out_data, 32'h11);
        check("fill_sel", out_sel, 1);
        check("fill_valid", out_valid, 1);

        // ch1 and ch3 both requesting
        in_valid = 4'b1010;
        for (int k = 0; k < 6; k++) begin
            rand_data();
            step();
`ifndef RR_ARB_MUX_RR_EN
            check("fp_starve", out_sel, 1);
`endif
        end
        in_valid = '0;
        step();

        // reset asserted while a word is held
        in_valid = 4'b0100;
        rand_data();
        step();
        out_ready = 1'b0;
        #2;
        resetn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        exp_q.delete();
        m_valid = 1'b0;
        m_ptr   = 0;
        @(posedge clk);
        #1;
        resetn    = 1'b1;
        out_ready = 1'b1;
        in_valid  = 4'b0010;
        step();
        check("post_reset_sel", out_sel, 1);

        // random traffic
        for (int k = 0; k < 300; k++) begin
            in_valid  = NCH'($urandom_range(0, 15));
            out_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            step();
        end

        in_valid  = '0;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) step();
        check("sb_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
RR_ARB_MUX -- requirements
Module: rr_arb_mux

Interface
REQ-001 Parameter WIDTH, default 32: data width of every channel and of the output, in bits.
REQ-002 Parameter NCH, default 4: number of input channels; the legal range is 1..16.
REQ-003 clk  input  1  is the single clock; all state updates on the rising edge.
REQ-004 resetn  input  1  is the asynchronous, active-low reset.
REQ-005 in_valid  input  NCH  carries one valid bit per channel; bit i belongs to channel i.
REQ-006 in_data  input  NCH*WIDTH  carries channel i data in bits [i*WIDTH +: WIDTH].
REQ-007 in_ready  output  NCH  carries one accept bit per channel.
REQ-008 out_valid  output  1  indicates that the output register holds valid data.
REQ-009 out_data  output  WIDTH  is the registered data of the selected channel.
REQ-010 out_sel  output  max(1,$clog2(NCH))  is the index of the channel whose data is in out_data.
REQ-011 out_ready  input  1  indicates that the downstream accepts out_data this cycle.

Function
REQ-012 Input transfer i SHALL occur when in_valid[i] and in_ready[i] are both 1 at a rising edge.
REQ-013 Output transfer SHALL occur when out_valid and out_ready are both 1 at a rising edge.
REQ-014 The block SHALL be able to load when out_valid is 0 or out_ready is 1 (load = !out_valid || out_ready).
REQ-015 At most one in_ready bit SHALL be 1 per cycle: in_ready[g] = load && in_valid[g], where g is the granted channel.
REQ-016 in_ready SHALL be combinational from in_valid, out_valid, out_ready and the priority pointer only, never from in_data.
REQ-017 On an input transfer from channel g: out_data <= in_data[g], out_sel <= g and out_valid <= 1, giving a latency of 1 cycle.
REQ-018 An output transfer with no simultaneous input transfer SHALL clear out_valid and leave out_data and out_sel unchanged.
REQ-019 A simultaneous output transfer and input transfer SHALL load the new data and keep out_valid at 1, allowing one transfer per cycle.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_sel and out_valid SHALL hold and all in_ready bits SHALL be 0.
REQ-021 With no in_valid bit set there SHALL be no grant, no state change and all in_ready bits at 0.
REQ-022 Grant SHALL go to the first channel with in_valid set, scanning upward from the pointer ptr and wrapping from NCH-1 to 0.
REQ-023 ptr SHALL update only on an input transfer: ptr <= (g+1) mod NCH, so that NCH-1 wraps to 0.
REQ-024 For NCH=1, ptr SHALL be constant 0 and the block SHALL behave as a one-entry pipeline register.
REQ-025 Sources SHALL hold in_valid and in_data until the transfer; the block's correctness does not depend on this.

Reset
REQ-026 resetn=0 SHALL asynchronously force out_valid=0, out_data=0, out_sel=0 and ptr=0.
REQ-027 Asserting reset mid-operation SHALL discard any held output word; in_ready SHALL read 0 during reset.
REQ-028 The first grant after reset release SHALL use ptr=0.

Configuration
REQ-029 Macro RR_ARB_MUX_RR_EN defined: round-robin arbitration as in REQ-022/REQ-023.
REQ-030 Macro RR_ARB_MUX_RR_EN undefined: fixed priority with the lowest-index valid channel winning, ptr removed (tied to 0), and all other behaviour identical.

Verification
REQ-031 Reset: with resetn=0 during arbitrary inputs -> out_valid=0, out_data=0, out_sel=0 and in_ready=0 throughout; first grant after release goes to channel 0.
REQ-032 Round-robin fairness: NCH=4, in_valid=4'b1111 held, out_ready=1 -> out_sel sequence 0,1,2,3,0 on consecutive cycles with out_valid=1 each cycle.
REQ-033 Backpressure: load ch2 data 32'hDEAD_BEEF, then out_ready=0 for 5 cycles -> out_data and out_sel=2 stable, in_ready=0; out_ready=1 -> transfer on the next edge.
REQ-034 Simultaneous drain and fill: out_valid=1, out_ready=1, in_valid[1]=1 with data 32'h0000_0011 -> next cycle out_data=32'h11, out_sel=1, out_valid=1.
REQ-035 Skip and wrap: ptr=3, in_valid=4'b0101 -> grant ch0, then ptr=1 -> next grant ch2, then ptr=3.
REQ-036 Fixed-priority build (macro undefined): in_valid=4'b1010 held -> ch1 granted every cycle and ch3 starved.
